// File: rtl/result_drain.sv
// result_drain: reads result BRAM R row by row and streams each row as one AXI-Stream beat.
// Optional checksum output is enabled by defining RESULT_DRAIN_CHECKSUM_EN.
module result_drain #(
    parameter int PE_COUNT     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           out_data_valid,
    input  logic [ADDR_WIDTH:0]            row_count,
    output logic [ADDR_WIDTH-1:0]          bram_r_r_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
    output logic [PE_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           busy,
    output logic                           done
`ifdef RESULT_DRAIN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]          checksum
`endif
);
    localparam int BW = PE_COUNT * DATA_WIDTH;
    localparam int RW = ADDR_WIDTH + 1;
    localparam int FD = READ_LATENCY + 1;
    localparam int PW = (FD > 2) ? $clog2(FD) : 1;
    localparam int NW = $clog2(FD + 1);
    localparam int CW = NW + 2;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t                  state;
    state_t                  nxt;
    logic                    prev;
    logic                    start;
    logic                    issue;
    logic                    can_issue;
    logic                    hs;
    logic                    arrive;
    logic                    push;
    logic                    pop;
    logic                    last;
    logic                    rd_en;
    logic [READ_LATENCY-1:0] sr;
    logic [RW-1:0]           rows;
    logic [RW-1:0]           issued;
    logic [RW-1:0]           beats;
    logic [RW-1:0]           issue_idx;
    logic [BW-1:0]           mem [FD];
    logic [PW-1:0]           wptr;
    logic [PW-1:0]           rptr;
    logic [NW-1:0]           cnt;
    logic [CW-1:0]           cred;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // prev resets high so a drain always needs a fresh rising edge after reset
    assign start     = out_data_valid & ~prev & (state == S_IDLE);
    assign arrive    = sr[READ_LATENCY-1];
    assign hs        = m_axis_tvalid & m_axis_tready;
    assign pop       = hs & (cnt != '0);
    assign push      = arrive & ~(hs & (cnt == '0));
    assign last      = (beats == rows - RW'(1));
    assign issue_idx = start ? '0 : issued;

    // Credit: slots owed to FIFO entries and reads in flight, net of this cycle's pop
    always_comb begin
        cred = CW'(cnt) + CW'(rd_en);
        for (int i = 0; i < READ_LATENCY; i++) begin
            cred = cred + CW'(sr[i]);
        end
        can_issue = (cred - CW'(hs)) < CW'(FD);
        if (start) begin
            issue = (row_count != '0);
        end else begin
            issue = (state == S_DRAIN) && (issued != rows) && can_issue;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = (row_count == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (issued == rows) nxt = S_FLUSH;
            S_FLUSH: if (hs && last) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs: FIFO head, or the returning BRAM word when the FIFO is empty
    always_comb begin
        m_axis_tvalid = (cnt != '0) | arrive;
        m_axis_tdata  = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata = (cnt != '0) ? mem[rptr] : bram_r_r_data;
        end
        m_axis_tlast  = m_axis_tvalid & last;
        busy          = start | (state == S_DRAIN) | (state == S_FLUSH);
        done          = (state == S_DONE);
    end

    // Read issue, latency tags and row/beat counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev          <= 1'b1;
            rows          <= '0;
            issued        <= '0;
            beats         <= '0;
            bram_r_r_addr <= '0;
            rd_en         <= 1'b0;
            sr            <= '0;
        end else begin
            prev  <= out_data_valid;
            rd_en <= issue;
            sr    <= READ_LATENCY'({sr, rd_en});
            if (start) begin
                rows  <= row_count;
                beats <= '0;
            end else if (hs) begin
                beats <= beats + RW'(1);
            end
            if (issue) begin
                bram_r_r_addr <= issue_idx[ADDR_WIDTH-1:0];
                issued        <= issue_idx + RW'(1);
            end else if (start) begin
                issued <= '0;
            end
            if (nxt == S_DONE) begin
                bram_r_r_addr <= '0;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave cnt unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            cnt <= cnt + NW'(push) - NW'(pop);
        end
    end

    // FIFO storage, contents are don't-care while cnt is zero
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bram_r_r_data;
    end

    // The credit check must make a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && cnt == NW'(FD)));

`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] lanes_x;

    // XOR of all lanes of the current beat
    always_comb begin
        lanes_x = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            lanes_x = lanes_x ^ m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Running checksum over accepted beats, cleared on the start edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (hs) begin
            checksum <= checksum ^ lanes_x;
        end
    end
`endif

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: table of drain vectors plus reset and checksum sequences.
// BRAM R is modelled as a two-register read pipeline.
module tb_result_drain;
    localparam int AW = 11;
    localparam int BW = 128;

    typedef struct {
        int         rows;
        logic [7:0] rdy;
        bit         again;
        int         first;
        int         done_at;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ovld = 1'b0;
    logic          tready = 1'b0;
    logic [AW:0]   row_count = '0;
    logic [AW-1:0] addr;
    logic [BW-1:0] rdata;
    logic [BW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          busy;
    logic          done;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [31:0]   checksum;
`endif
    logic [BW-1:0] mem [2048];
    logic [BW-1:0] d1;
    logic [BW-1:0] d2;
    int            errors = 0;
    int            checks = 0;
    vec_t          vecs [7];

    result_drain dut (
        .clk            (clk),
        .rstn           (rstn),
        .out_data_valid (ovld),
        .row_count      (row_count),
        .bram_r_r_addr  (addr),
        .bram_r_r_data  (rdata),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .done           (done)
`ifdef RESULT_DRAIN_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= mem[addr];
        d2 <= d1;
    end
    assign rdata = d2;

    function automatic logic [BW-1:0] row_word(input int k);
        logic [BW-1:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = 32'(4 * k + j);
        return w;
    endfunction

    task automatic check(input string name, input logic [159:0] got,
                         input logic [159:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int beats = 0;
        int first = -1;
        int done_at = -1;
        int done_cnt = 0;
        int busy_bad = 0;
        int cyc = 0;
        int budget = 4 * v.rows + 40;
        logic held = 1'b0;
        logic hlast = 1'b0;
        logic [BW-1:0] hdata = '0;
        @(negedge clk);
        row_count = (AW+1)'(v.rows);
        ovld = 1'b1;
        #1 check({tag, " busy_at_start"}, busy, 1'b1);
        @(posedge clk);
        while (cyc < budget && !(done_cnt > 0 && cyc > done_at + 3)) begin
            @(negedge clk);
            if (cyc == 0) begin
                ovld = 1'b0;
                row_count = 12'd7;
            end
            if (v.again && cyc == 6) ovld = 1'b1;
            if (v.again && cyc == 7) ovld = 1'b0;
            if (held) begin
                check({tag, " stall_hold"}, {tvalid, tlast, tdata},
                      {1'b1, hlast, hdata});
            end
            tready = v.rdy[cyc % 8];
            if (tvalid && first < 0) first = cyc;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_cnt == 0 && !done && !busy) busy_bad++;
            if (done && busy) busy_bad++;
            if (tvalid && tready) begin
                check({tag, " beat"}, {tlast, tdata},
                      {beats == v.rows - 1, mem[beats]});
                beats++;
            end
            held = tvalid && !tready;
            hdata = tdata;
            hlast = tlast;
            cyc++;
        end
        check({tag, " beat_count"}, beats, v.rows);
        check({tag, " first_tvalid"}, first, v.first);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_shape"}, busy_bad, 0);
        if (v.done_at >= 0) check({tag, " done_cycle"}, done_at, v.done_at);
    endtask

    initial begin
        int acc;
        int n;
        for (int k = 0; k < 2048; k++) mem[k] = row_word(k);
        vecs[0] = '{rows: 4,    rdy: 8'hFF,        again: 0, first: 2,  done_at: 6};
        vecs[1] = '{rows: 8,    rdy: 8'b1001_1001, again: 0, first: 2,  done_at: -1};
        vecs[2] = '{rows: 0,    rdy: 8'hFF,        again: 0, first: -1, done_at: 0};
        vecs[3] = '{rows: 16,   rdy: 8'hFF,        again: 1, first: 2,  done_at: 18};
        vecs[4] = '{rows: 1,    rdy: 8'hFF,        again: 0, first: 2,  done_at: 3};
        vecs[5] = '{rows: 2048, rdy: 8'hFF,        again: 0, first: 2,  done_at: 2050};
        vecs[6] = '{rows: 5,    rdy: 8'b0101_0101, again: 0, first: 2,  done_at: -1};

        repeat (3) @(negedge clk);
        check("reset_ctrl", {tvalid, tlast, busy, done}, 4'b0);
        check("reset_tdata", tdata, '0);
        check("reset_addr", addr, '0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("v%0d", i));

        @(negedge clk);
        row_count = 12'd10;
        ovld = 1'b1;
        tready = 1'b0;
        @(negedge clk);
        ovld = 1'b0;
        acc = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            tready = (acc < 5);
            if (acc == 5 && tvalid) break;
            if (tvalid && tready) begin
                check("rst_pre_beat", tdata, mem[acc]);
                acc++;
            end
        end
        check("rst_row5_waiting", {acc[7:0], tvalid}, {8'd5, 1'b1});
        @(negedge clk);
        check("rst_row5_data", {tvalid, tdata}, {1'b1, mem[5]});
        rstn = 1'b0;
        #1;
        check("rst_mid_ctrl", {tvalid, tlast, busy, done}, 4'b0);
        check("rst_mid_tdata", tdata, '0);
        check("rst_mid_addr", addr, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_restart", {tvalid, busy}, 2'b0);
        run('{rows: 3, rdy: 8'hFF, again: 0, first: 2, done_at: 5}, "rearm");

`ifdef RESULT_DRAIN_CHECKSUM_EN
        mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[1] = {32'd8, 32'd7, 32'd6, 32'd5};
        run('{rows: 2, rdy: 8'hFF, again: 0, first: 2, done_at: 4}, "csum");
        check("csum_value", checksum, 32'h8);
        run('{rows: 0, rdy: 8'hFF, again: 0, first: -1, done_at: 0}, "csum0");
        check("csum_zero_rows", checksum, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
